// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  // RISC-V M-extension divide/remainder operations; op[1] selects remainder.
  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient returned for a zero divisor; sliced down to XLEN by the user.
  localparam logic [63:0] DIV_ZERO_QUO = '1;

  function automatic logic is_rem_op(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

  function automatic logic is_signed_op(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   i_acc,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvs,
  output logic [XLEN:0]   o_acc,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_dvs_ext;
  // The partial remainder is always below the divisor, so its top bit is never set.
  logic          w_unused_acc_msb;

  assign w_unused_acc_msb = i_acc[XLEN];
  assign w_shift          = {i_acc[XLEN-1:0], i_quo[XLEN-1]};
  assign w_dvs_ext        = {1'b0, i_dvs};

  // Shift in the next dividend bit, subtract when it fits and record the quotient bit.
  always_comb begin
    o_acc = w_shift;
    o_quo = {i_quo[XLEN-2:0], 1'b0};
    if (w_shift >= w_dvs_ext) begin
      o_acc = w_shift - w_dvs_ext;
      o_quo = {i_quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU).
// Optional feature macro: DIV_SIGNED_EN enables signed DIV/REM; without it
// every op is unsigned and op_i[0] is ignored.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] opr1_i,
  input  logic [XLEN-1:0] opr2_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] res_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  div_state_e      r_state;
  div_state_e      w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]   r_acc;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_res;
  logic            r_rem_op;

  logic [XLEN:0]   w_acc_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_ovf;
  logic            w_dbz;
  logic            w_special;
  logic            w_is_rem;
  logic            w_accept;
  logic            w_last;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;
  logic [XLEN-1:0] w_fin_res;

  assign w_is_rem = is_rem_op(div_op_e'(op_i));
  assign w_dbz    = (opr2_i == '0);
  assign w_accept = valid_i && (r_state == IDLE) && !kill_i;
  assign w_last   = (r_cnt == CNT_W'(XLEN - 1));

`ifdef DIV_SIGNED_EN
  logic w_signed;
  logic w_sign1;
  logic w_sign2;
  logic r_neg_q;
  logic r_neg_r;

  assign w_signed = is_signed_op(div_op_e'(op_i));
  assign w_sign1  = w_signed & opr1_i[XLEN-1];
  assign w_sign2  = w_signed & opr2_i[XLEN-1];
  assign w_mag1   = w_sign1 ? -opr1_i : opr1_i;
  assign w_mag2   = w_sign2 ? -opr2_i : opr2_i;
  assign w_ovf    = w_signed && (opr1_i == {1'b1, {(XLEN-1){1'b0}}}) && (opr2_i == '1);
`else
  assign w_mag1   = opr1_i;
  assign w_mag2   = opr2_i;
  assign w_ovf    = 1'b0;
`endif

  assign w_special = w_dbz || w_ovf;

  // Result for the single-cycle divide-by-zero and overflow paths.
  always_comb begin
    w_special_res = '0;
    if (w_dbz) begin
      w_special_res = w_is_rem ? opr1_i : DIV_ZERO_QUO[XLEN-1:0];
    end else if (w_ovf) begin
      w_special_res = w_is_rem ? '0 : opr1_i;
    end
  end

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_acc(r_acc),
    .i_quo(r_quo),
    .i_dvs(r_dvs),
    .o_acc(w_acc_nxt),
    .o_quo(w_quo_nxt)
  );

  // Final result from the last iteration, with sign correction folded in.
  always_comb begin
    w_q_fin = w_quo_nxt;
    w_r_fin = w_acc_nxt[XLEN-1:0];
`ifdef DIV_SIGNED_EN
    if (r_neg_q) w_q_fin = -w_quo_nxt;
    if (r_neg_r) w_r_fin = -w_acc_nxt[XLEN-1:0];
`endif
    w_fin_res = r_rem_op ? w_r_fin : w_q_fin;
  end

  // Next-state logic; kill overrides every other transition.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (valid_i) w_state_d = w_special ? DONE : CALC;
      CALC:    if (w_last) w_state_d = DONE;
      DONE:    if (ready_i) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    if (kill_i) w_state_d = IDLE;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Operand capture on accept, one iteration per CALC cycle, result on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_res    <= '0;
      r_rem_op <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_quo    <= w_mag1;
      r_dvs    <= w_mag2;
      r_rem_op <= w_is_rem;
      if (w_special) r_res <= w_special_res;
    end else if ((r_state == CALC) && !kill_i) begin
      r_acc <= w_acc_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_res <= w_fin_res;
    end
  end

`ifdef DIV_SIGNED_EN
  // Sign flags captured alongside the operand magnitudes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_sign1 ^ w_sign2;
      r_neg_r <= w_sign1;
    end
  end
`endif

  assign ready_o = (r_state == IDLE);
  assign valid_o = (r_state == DONE);
  assign res_o   = r_res;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against a behavioural divide model.
module tb_seq_divider;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [1:0]      op_i = 2'd0;
  logic [XLEN-1:0] opr1_i = '0;
  logic [XLEN-1:0] opr2_i = '0;
  logic            kill_i = 1'b0;
  logic            valid_o;
  logic            ready_i = 1'b1;
  logic [XLEN-1:0] res_o;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  seq_divider #(
    .XLEN(XLEN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .op_i   (op_i),
    .opr1_i (opr1_i),
    .opr2_i (opr2_i),
    .kill_i (kill_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .res_o  (res_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an operation, straight from the ISA rules.
  function automatic logic [31:0] model_res(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    bit sgn;
    sgn = (op[0] == 1'b0);
`ifndef DIV_SIGNED_EN
    sgn = 1'b0;
`endif
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    if (sgn) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Edges from accept (counting the accept edge) until valid_o is seen.
  function automatic int model_lat(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    bit sgn;
    sgn = (op[0] == 1'b0);
`ifndef DIV_SIGNED_EN
    sgn = 1'b0;
`endif
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Behavioural model: idle / countdown-busy / holding-result.
  int          m_left = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk) begin : model
    int lat;
    if (!rst) begin
      m_left  <= 0;
      m_valid <= 1'b0;
      m_res   <= '0;
    end else if (kill_i) begin
      m_left  <= 0;
      m_valid <= 1'b0;
    end else if (m_valid) begin
      if (ready_i) m_valid <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_res   <= m_pend;
      end
    end else if (valid_i) begin
      lat = model_lat(op_i, opr1_i, opr2_i);
      m_pend <= model_res(op_i, opr1_i, opr2_i);
      m_left <= lat - 1;
      if (lat == 1) begin
        m_valid <= 1'b1;
        m_res   <= model_res(op_i, opr1_i, opr2_i);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_o", 64'(ready_o), 64'(!m_valid && m_left == 0));
      check("valid_o", 64'(valid_o), 64'(m_valid));
      check("res_o", 64'(res_o), 64'(m_res));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int waited);
    waited = 0;
    while (!ready_o && waited < 200) begin
      tick();
      waited++;
    end
    if (!ready_o) check("ready_wait", 64'(ready_o), 64'd1);
    valid_i = 1'b1;
    op_i    = op;
    opr1_i  = a;
    opr2_i  = b;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int n;
    int w;
    ready_i = (hold == 0);
    issue(op, a, b, w);
    n = 1;
    while (!valid_o && n < 200) begin
      tick();
      n++;
    end
    check({name, "_lat"}, 64'(n), 64'(exp_lat));
    check({name, "_res"}, 64'(res_o), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, "_bp_res"}, 64'(res_o), 64'(exp));
      check({name, "_bp_valid"}, 64'(valid_o), 64'd1);
      check({name, "_bp_ready"}, 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] neg7;

    tick();
    chk_en = 1'b1;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_res", 64'(res_o), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Hand-computed pins for the model and the DUT.
    run_op("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 33, 0);
    neg7 = 32'hFFFF_FFF9;
`ifdef DIV_SIGNED_EN
    run_op("div_m7_2", 2'd0, neg7, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2", 2'd2, neg7, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
`else
    run_op("div_m7_2", 2'd0, neg7, 32'd2, 32'h7FFF_FFFC, 33, 0);
    run_op("rem_m7_2", 2'd2, neg7, 32'd2, 32'h1, 33, 0);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 0);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
`endif
    run_op("divu_5_0", 2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_5_0", 2'd3, 32'd5, 32'd0, 32'd5, 1, 0);

    // Backpressure, then back-to-back accept on the edge after release.
    run_op("bp_divu", 2'd1, 32'd1000, 32'd9, 32'd111, 33, 10);
    issue(2'd1, 32'd50, 32'd5, w);
    check("accept_next_wait", 64'(w), 64'd0);
    check("accept_next_busy", 64'(ready_o), 64'd0);
    for (int i = 0; i < 40 && !valid_o; i++) tick();
    check("accept_next_res", 64'(res_o), 64'd10);
    tick();

    // Kill mid-calculation, then a fresh op with normal latency.
    issue(2'd1, 32'd100, 32'd7, w);
    repeat (10) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check("kill_valid", 64'(valid_o), 64'd0);
    check("kill_ready", 64'(ready_o), 64'd1);
    run_op("after_kill", 2'd1, 32'd9, 32'd3, 32'd3, 33, 0);

    // Kill in the same cycle as an accept cancels it.
    valid_i = 1'b1;
    op_i    = 2'd1;
    opr1_i  = 32'd77;
    opr2_i  = 32'd0;
    kill_i  = 1'b1;
    tick();
    valid_i = 1'b0;
    kill_i  = 1'b0;
    check("kill_accept_ready", 64'(ready_o), 64'd1);
    check("kill_accept_valid", 64'(valid_o), 64'd0);

    // Reset mid-calculation.
    issue(2'd1, 32'd100, 32'd7, w);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_mid_valid", 64'(valid_o), 64'd0);
    check("rst_mid_ready", 64'(ready_o), 64'd1);
    check("rst_mid_res", 64'(res_o), 64'd0);

    // Randomized operations with occasional backpressure and kills.
    for (int k = 0; k < 150; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      if (k % 10 == 9) begin
        ready_i = 1'b1;
        issue(op, a, b, w);
        repeat ($urandom_range(0, 36)) tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
      end else begin
        run_op("rand", op, a, b, model_res(op, a, b), model_lat(op, a, b),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
